// File: rtl/mem_read_responder_pkg.sv
// Shared memory-map constants, bank ids and responder state encoding.
// The address decoder imports the same package so both sides agree on the map.
package mem_read_responder_pkg;

  localparam logic [2:0] MEM_EN_DATA = 3'b001;
  localparam logic [2:0] MEM_EN_VGA  = 3'b010;

  localparam logic [1:0] BANK_DATA = 2'd0;
  localparam logic [1:0] BANK_VGA  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Decoder-side helper: bank id implied by a well-formed enable.
  function automatic logic [1:0] bank_of_en(input logic [2:0] en);
    return (en == MEM_EN_VGA) ? BANK_VGA : BANK_DATA;
  endfunction

  function automatic logic en_malformed(input logic [2:0] en);
    return !$onehot(en);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter: load a start value, decrement to zero, flag zero.
module mem_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_read_responder.sv
// CPU data-memory return path: waits out per-bank read latency, returns data, flags bad addresses.
// Optional MEM_RESP_BADVADDR_EN adds a sticky bad_vaddr capture of the last faulting address.
module mem_read_responder
  import mem_read_responder_pkg::*;
#(
  parameter int DATA_LAT = 1,
  parameter int VGA_LAT  = 2,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  mem_en,
  input  logic [1:0]  mem_bank,
  input  logic        inv_addr,
  input  logic [31:0] virt_addr,
  input  logic [31:0] data_rdata,
  input  logic [31:0] vga_rdata,
  output logic [31:0] cpu_rdata,
  output logic        resp_valid,
  output logic        busy,
`ifdef MEM_RESP_BADVADDR_EN
  output logic [31:0] bad_vaddr,
`endif
  output logic        addr_exc
);

  if (DATA_LAT < 1 || DATA_LAT > 2**CNT_W) begin : g_bad_data_lat
    $error("mem_read_responder: DATA_LAT out of range for CNT_W");
  end
  if (VGA_LAT < 1 || VGA_LAT > 2**CNT_W) begin : g_bad_vga_lat
    $error("mem_read_responder: VGA_LAT out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_LAT - 1);
  localparam logic [CNT_W-1:0] VGA_LOAD  = CNT_W'(VGA_LAT - 1);

  state_t           state, state_nx;
  logic [1:0]       bank_q;
  logic             write_q;
  logic             cnt_load, cnt_zero, acc_err;
  logic [CNT_W-1:0] lat_load;
  logic [31:0]      sel_rdata;

  assign acc_err = inv_addr || en_malformed(mem_en);
  assign busy    = (state == S_WAIT);

  always_comb begin
    lat_load = DATA_LOAD;
    case (mem_bank)
      BANK_DATA: lat_load = DATA_LOAD;
      BANK_VGA:  lat_load = VGA_LOAD;
      default:   lat_load = DATA_LOAD;
    endcase
  end

  // Return mux follows the bank latched at accept, never the live decoder output.
  always_comb begin
    sel_rdata = data_rdata;
    case (bank_q)
      BANK_DATA: sel_rdata = data_rdata;
      BANK_VGA:  sel_rdata = vga_rdata;
      default:   sel_rdata = data_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    case (state)
      S_WAIT: begin
        if (cnt_zero) state_nx = S_RESP;
      end
      default: begin
        if (!req_valid) begin
          state_nx = S_IDLE;
        end else if (acc_err) begin
          state_nx = S_ERR;
        end else begin
          state_nx = S_WAIT;
          cnt_load = 1'b1;
        end
      end
    endcase
  end

  mem_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lat_load),
    .dec      (busy),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bank_q     <= BANK_DATA;
      write_q    <= 1'b0;
      cpu_rdata  <= '0;
      resp_valid <= 1'b0;
      addr_exc   <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= (state_nx == S_RESP) || (state_nx == S_ERR);
      addr_exc   <= (state_nx == S_ERR);
      if (cnt_load) begin
        bank_q  <= mem_bank;
        write_q <= req_write;
      end
      if (state_nx == S_ERR) begin
        cpu_rdata <= '0;
      end else if (busy && cnt_zero) begin
        cpu_rdata <= write_q ? '0 : sel_rdata;
      end
    end
  end

`ifdef MEM_RESP_BADVADDR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_vaddr <= '0;
    end else if (state_nx == S_ERR) begin
      bad_vaddr <= virt_addr;
    end
  end
`else
  logic unused_virt_addr;
  assign unused_virt_addr = ^virt_addr;
`endif

endmodule

// File: tb/tb_mem_read_responder.sv
// Randomized bench for mem_read_responder against a per-edge expectation timeline.
module tb_mem_read_responder;

  localparam int DATA_LAT = 1;
  localparam int VGA_LAT  = 2;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 4096;
  localparam int NRAND    = 2500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        inv_addr = 1'b0;
  logic [2:0]  mem_en = 3'b000;
  logic [1:0]  mem_bank = 2'b00;
  logic [31:0] virt_addr = '0;
  logic [31:0] data_rdata = '0;
  logic [31:0] vga_rdata = '0;
  logic [31:0] cpu_rdata;
  logic        resp_valid;
  logic        busy;
  logic        addr_exc;
`ifdef MEM_RESP_BADVADDR_EN
  logic [31:0] bad_vaddr;
`endif

  mem_read_responder #(.DATA_LAT(DATA_LAT), .VGA_LAT(VGA_LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .mem_en     (mem_en),
    .mem_bank   (mem_bank),
    .inv_addr   (inv_addr),
    .virt_addr  (virt_addr),
    .data_rdata (data_rdata),
    .vga_rdata  (vga_rdata),
    .cpu_rdata  (cpu_rdata),
    .resp_valid (resp_valid),
    .busy       (busy),
`ifdef MEM_RESP_BADVADDR_EN
    .bad_vaddr  (bad_vaddr),
`endif
    .addr_exc   (addr_exc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs as seen after edge number e.
  bit          exp_busy [DEPTH];
  bit          exp_resp [DEPTH];
  bit          exp_exc  [DEPTH];
  logic [31:0] exp_data [DEPTH];
  logic [31:0] exp_bad  [DEPTH];

  int          e = 0;
  int          free_edge = 0;
  int          pend_edge = -1;
  bit          pend_vga = 1'b0;
  bit          pend_wr = 1'b0;
  logic [31:0] bad_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask

  // Timeline model: an accepted load at edge a keeps busy for LAT cycles, responds after
  // edge a+LAT with the bank data present at that edge, and frees the port at a+LAT+1.
  task automatic model_edge();
    int lat;
    if (rst) begin
      for (int i = e; i < DEPTH; i++) begin
        exp_busy[i] = 1'b0; exp_resp[i] = 1'b0; exp_exc[i] = 1'b0;
        exp_data[i] = '0;   exp_bad[i]  = '0;
      end
      free_edge = e + 1;
      pend_edge = -1;
      bad_model = '0;
      return;
    end
    if (pend_edge == e) begin
      exp_data[e] = pend_wr ? 32'h0 : (pend_vga ? vga_rdata : data_rdata);
      pend_edge = -1;
    end
    if (req_valid && e >= free_edge) begin
      if (inv_addr || $countones(mem_en) != 1) begin
        exp_resp[e] = 1'b1;
        exp_exc[e]  = 1'b1;
        exp_data[e] = '0;
        bad_model   = virt_addr;
        free_edge   = e + 1;
      end else begin
        lat = (mem_bank == 2'd1) ? VGA_LAT : DATA_LAT;
        for (int i = 0; i < lat; i++) exp_busy[e + i] = 1'b1;
        exp_resp[e + lat] = 1'b1;
        pend_edge = e + lat;
        pend_vga  = (mem_bank == 2'd1);
        pend_wr   = req_write;
        free_edge = e + lat + 1;
      end
    end
    exp_bad[e] = bad_model;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    check("busy", 32'(busy), 32'(exp_busy[e]));
    check("resp_valid", 32'(resp_valid), 32'(exp_resp[e]));
    check("addr_exc", 32'(addr_exc), 32'(exp_exc[e]));
    if (exp_resp[e]) check("cpu_rdata", cpu_rdata, exp_data[e]);
`ifdef MEM_RESP_BADVADDR_EN
    check("bad_vaddr", bad_vaddr, exp_bad[e]);
`endif
    e++;
  endtask

  task automatic drive(input bit v, input bit w, input logic [2:0] en, input logic [1:0] bk,
                       input bit inv, input logic [31:0] va);
    req_valid = v; req_write = w; mem_en = en; mem_bank = bk; inv_addr = inv; virt_addr = va;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_resp"}, 32'(resp_valid), 32'h0);
    check({tag, "_exc"}, 32'(addr_exc), 32'h0);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    int k;
    logic [2:0] bad_en [5];
    bad_en[0] = 3'b000; bad_en[1] = 3'b011; bad_en[2] = 3'b101;
    bad_en[3] = 3'b110; bad_en[4] = 3'b111;

    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Data load, one busy cycle
    data_rdata = 32'hDEADBEEF;
    drive(1, 0, 3'b001, 2'd0, 0, 32'h0);
    tick();
    check("data_busy", 32'(busy), 32'h1);
    drive(0, 0, 3'b000, 2'd0, 0, 32'h0);
    tick();
    check("data_resp", 32'(resp_valid), 32'h1);
    check("data_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();

    // VGA load, two busy cycles
    vga_rdata = 32'h00000741;
    drive(1, 0, 3'b010, 2'd1, 0, 32'h0);
    tick();
    check("vga_busy1", 32'(busy), 32'h1);
    drive(0, 0, 3'b000, 2'd0, 0, 32'h0);
    tick();
    check("vga_busy2", 32'(busy), 32'h1);
    tick();
    check("vga_resp", 32'(resp_valid), 32'h1);
    check("vga_rdata", cpu_rdata, 32'h00000741);
    check("vga_exc", 32'(addr_exc), 32'h0);
    tick();

    // Invalid address, then malformed enable accepted at the ERR exit edge
    drive(1, 0, 3'b001, 2'd0, 1, 32'h00000100);
    tick();
    check("inv_resp", 32'(resp_valid), 32'h1);
    check("inv_exc", 32'(addr_exc), 32'h1);
    check("inv_rdata", cpu_rdata, 32'h0);
`ifdef MEM_RESP_BADVADDR_EN
    check("inv_badv", bad_vaddr, 32'h00000100);
`endif
    drive(1, 0, 3'b011, 2'd0, 0, 32'h00000200);
    tick();
    check("men_exc", 32'(addr_exc), 32'h1);
    drive(0, 0, 3'b000, 2'd0, 0, 32'h0);
    tick();
    check("err_exit", 32'(resp_valid), 32'h0);

    // Store, request toggled during WAIT, then load at the RESP exit edge
    data_rdata = 32'h12345678;
    drive(1, 1, 3'b001, 2'd0, 0, 32'h0);
    tick();
    drive(1, 0, 3'b011, 2'd0, 0, 32'h0);
    tick();
    check("st_resp", 32'(resp_valid), 32'h1);
    check("st_rdata", cpu_rdata, 32'h0);
    check("st_exc", 32'(addr_exc), 32'h0);
    data_rdata = 32'hCAFE0001;
    drive(1, 0, 3'b001, 2'd0, 0, 32'h0);
    tick();
    check("b2b_busy", 32'(busy), 32'h1);
    drive(0, 0, 3'b000, 2'd0, 0, 32'h0);
    tick();
    check("ld_resp", 32'(resp_valid), 32'h1);
    check("ld_rdata", cpu_rdata, 32'hCAFE0001);
    tick();

    // Reset in the middle of WAIT
    drive(1, 0, 3'b010, 2'd1, 0, 32'h0);
    tick();
    drive(0, 0, 3'b000, 2'd0, 0, 32'h0);
    rst = 1'b1;
    #1;
    check_all_zero("midwait");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_resp", 32'(resp_valid), 32'h0);
    end

    // Random traffic
    for (int n = 0; n < NRAND; n++) begin
      data_rdata = $urandom;
      vga_rdata  = $urandom;
      virt_addr  = $urandom;
      req_valid  = ($urandom_range(0, 2) != 0);
      req_write  = $urandom_range(0, 1) == 1;
      inv_addr   = 1'b0;
      k = $urandom_range(0, 9);
      if (k <= 3 || k == 9) begin
        mem_en = 3'b001; mem_bank = 2'd0;
      end else if (k <= 6) begin
        mem_en = 3'b010; mem_bank = 2'd1;
      end else if (k == 7) begin
        inv_addr = 1'b1;
        mem_bank = 2'($urandom_range(0, 1));
        mem_en   = (mem_bank == 2'd1) ? 3'b010 : 3'b001;
      end else begin
        mem_en   = bad_en[$urandom_range(0, 4)];
        mem_bank = 2'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        check("rnd_rst_busy", 32'(busy), 32'h0);
        check("rnd_rst_resp", 32'(resp_valid), 32'h0);
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
